keypoint_sched: RTL



---
 rtl/keypoint_sched_pkg.sv | 16 +
 rtl/kp_fifo.sv | 46 ++++
 rtl/keypoint_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keypoint_sched_pkg.sv
// Shared types and constants for the keypoint scheduler: FSM encoding and
// counter widths that match the compare-stage seed counter.
package keypoint_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_SEED_DEF = 511;
  localparam int KP_CNT_W     = 9;
  localparam int DROP_W       = 8;

endpackage

// File: rtl/kp_fifo.sv
// Per-requester synchronous FIFO with flush. The read port is combinational so
// the scheduler can load its output register the cycle after a write.
module kp_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypoint_sched.sv
// Collects keypoints from NREQ compare instances into FIFOs and hands them to
// the descriptor stage round-robin, with a per-frame seed cap and completion.
module keypoint_sched
  import keypoint_sched_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int CNT_DW     = 16,
  parameter int SW         = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_SEED   = MAX_SEED_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*CNT_DW-1:0] req_addr,
  input  logic [NREQ-1:0]        req_end,
  output logic                   kp_valid,
  input  logic                   kp_ready,
  output logic [CNT_DW-1:0]      kp_addr,
  output logic [SW-1:0]          kp_scale,
  output logic [8:0]             kp_count,
  output logic [7:0]             drop_cnt,
  output logic                   overflow,
  output logic                   busy,
  output logic                   frame_done
);

  logic [NREQ-1:0]     fifo_full;
  logic [NREQ-1:0]     fifo_empty;
  logic [NREQ-1:0]     push_en;
  logic [NREQ-1:0]     pop_en;
  logic [CNT_DW-1:0]   fifo_data [NREQ];

  state_t              state_q;
  logic [NREQ-1:0]     end_q;
  logic [SW-1:0]       rr_q;
  logic                kp_valid_q;
  logic [CNT_DW-1:0]   kp_addr_q;
  logic [SW-1:0]       kp_scale_q;
  logic [KP_CNT_W-1:0] kp_count_q, kp_count_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                overflow_q, overflow_d;
  logic                busy_q;
  logic                done_q;

  logic                load_en;
  logic                grant_any;
  logic [SW-1:0]       grant_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    kp_fifo #(.DW(CNT_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (frame_start),
      .wr_en_i   (push_en[gi]),
      .wr_data_i (req_addr[gi*CNT_DW +: CNT_DW]),
      .rd_en_i   (pop_en[gi]),
      .rd_data_o (fifo_data[gi]),
      .full_o    (fifo_full[gi]),
      .empty_o   (fifo_empty[gi])
    );
  end

  // Pushes resolve in requester order so the seed cap is exact within a cycle.
  always_comb begin
    kp_count_d = kp_count_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    push_en    = '0;
    if (state_q == ST_RUN && !frame_start) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          if (fifo_full[i]) begin
            overflow_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + 1'b1;
          end else if (kp_count_d == KP_CNT_W'(MAX_SEED)) begin
            if (drop_d != '1) drop_d = drop_d + 1'b1;
          end else begin
            push_en[i] = 1'b1;
            kp_count_d = kp_count_d + 1'b1;
          end
        end
      end
    end
  end

  // rr_q names the first requester to consider on the next load.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    pop_en    = '0;
    load_en   = (state_q == ST_RUN || state_q == ST_DRAIN) && !frame_start &&
                (!kp_valid_q || kp_ready);
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!grant_any && !fifo_empty[idx]) begin
        grant_any = 1'b1;
        grant_idx = SW'(idx);
      end
    end
    if (load_en && grant_any) pop_en[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      end_q      <= '0;
      rr_q       <= '0;
      kp_valid_q <= 1'b0;
      kp_addr_q  <= '0;
      kp_scale_q <= '0;
      kp_count_q <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (frame_start) begin
      state_q    <= ST_RUN;
      end_q      <= '0;
      rr_q       <= '0;
      kp_valid_q <= 1'b0;
      kp_count_q <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      kp_count_q <= kp_count_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      if (load_en) begin
        kp_valid_q <= grant_any;
        if (grant_any) begin
          kp_addr_q  <= fifo_data[grant_idx];
          kp_scale_q <= grant_idx;
          rr_q       <= (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      case (state_q)
        ST_RUN: begin
          end_q <= end_q | req_end;
          if (&(end_q | req_end)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (&fifo_empty && !kp_valid_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: ;
      endcase
    end
  end

  assign kp_valid   = kp_valid_q;
  assign kp_addr    = kp_addr_q;
  assign kp_scale   = kp_scale_q;
  assign kp_count   = kp_count_q;
  assign drop_cnt   = drop_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
